// File: rtl/mem_pkg.sv
// Shared types and defaults for the pipeline memory controller.
package mem_pkg;

  localparam int unsigned LATENCIA_PADRAO     = 2;
  localparam int unsigned PROFUNDIDADE_PADRAO = 256;
  localparam int unsigned LARGURA_PALAVRA     = 32;
  localparam int unsigned LARGURA_CONTADOR    = 4;

  typedef logic [LARGURA_PALAVRA-1:0] palavra_t;

  typedef enum logic [1:0] {
    OCIOSO   = 2'd0,
    ESPERA   = 2'd1,
    RESPOSTA = 2'd2
  } estado_t;

  // Index width for a given depth; a depth of 1 still needs one address bit.
  function automatic int unsigned largura_indice(input int unsigned prof);
    return (prof > 1) ? $clog2(prof) : 1;
  endfunction

endpackage

// File: rtl/memoria_ram.sv
// Single-port PROFUNDIDADE x 32 storage: synchronous write, registered read.
// The read register resets to zero; the array itself is never cleared.
module memoria_ram
  import mem_pkg::*;
#(
  parameter int unsigned PROFUNDIDADE = PROFUNDIDADE_PADRAO,
  parameter int unsigned AW           = largura_indice(PROFUNDIDADE)
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       habilita,
  input  logic                       escreve,
  input  logic [AW-1:0]              indice,
  input  logic [LARGURA_PALAVRA-1:0] dado_escrita,
  output logic [LARGURA_PALAVRA-1:0] dado_leitura
);

  palavra_t mem_q [PROFUNDIDADE];
  palavra_t leitura_q;
  palavra_t leitura_d;

  always_ff @(posedge clock) begin
    if (habilita && escreve) begin
      mem_q[indice] <= dado_escrita;
    end
  end

  // Read data holds its value unless a read is performed.
  always_comb begin
    leitura_d = leitura_q;
    if (habilita && !escreve) begin
      leitura_d = mem_q[indice];
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      leitura_q <= '0;
    end else begin
      leitura_q <= leitura_d;
    end
  end

  assign dado_leitura = leitura_q;

endmodule

// File: rtl/controlador_memoria.sv
// Memory controller with LATENCIA wait cycles per access and a stall output.
// Define MEM_VERIFICA_ERRO_EN to reject misaligned or out-of-range addresses.
module controlador_memoria
  import mem_pkg::*;
#(
  parameter int unsigned LATENCIA     = LATENCIA_PADRAO,
  parameter int unsigned PROFUNDIDADE = PROFUNDIDADE_PADRAO
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        ler,
  input  logic        escreve,
  input  logic [31:0] endereco,
  input  logic [31:0] dadoEscrita,
  output logic [31:0] saidaMemoria,
  output logic        pronto,
  output logic        ocupado,
  output logic        erro
);

  localparam int unsigned AW = largura_indice(PROFUNDIDADE);
  localparam int unsigned CW = LARGURA_CONTADOR;
  localparam logic [CW-1:0] CARGA = CW'((LATENCIA > 0) ? (LATENCIA - 1) : 0);

  estado_t       estado_q, estado_d;
  logic [CW-1:0] contador_q, contador_d;
  logic [AW-1:0] indice_q, indice_d;
  palavra_t      dado_q, dado_d;
  logic          leitura_q, leitura_d;
  logic          pronto_q, pronto_d;
  logic          ocupado_q, ocupado_d;
  logic          erro_q, erro_d;

  logic [29:0]   palavra_c;
  logic [AW-1:0] indice_c;
  logic          invalido_c;
  logic          ram_hab_c;

  assign palavra_c = endereco[31:2];

`ifdef MEM_VERIFICA_ERRO_EN
  assign invalido_c = (endereco[1:0] != 2'b00) ||
                      (32'(palavra_c) >= 32'(PROFUNDIDADE));
  assign indice_c   = AW'(palavra_c);
`else
  // Byte offset is irrelevant here; the word index wraps around the array.
  logic unused_c;
  assign unused_c   = ^endereco[1:0];
  assign invalido_c = 1'b0;
  assign indice_c   = AW'(32'(palavra_c) % 32'(PROFUNDIDADE));
`endif

  // Next-state and output logic.
  always_comb begin
    estado_d   = estado_q;
    contador_d = contador_q;
    indice_d   = indice_q;
    dado_d     = dado_q;
    leitura_d  = leitura_q;
    pronto_d   = 1'b0;
    erro_d     = 1'b0;
    ram_hab_c  = 1'b0;

    case (estado_q)
      OCIOSO: begin
        if (ler && escreve) begin
          erro_d = 1'b1;
        end else if (ler || escreve) begin
          if (invalido_c) begin
            erro_d = 1'b1;
          end else begin
            indice_d  = indice_c;
            dado_d    = dadoEscrita;
            leitura_d = ler;
            if (LATENCIA == 0) begin
              estado_d = RESPOSTA;
            end else begin
              estado_d   = ESPERA;
              contador_d = CARGA;
            end
          end
        end
      end
      ESPERA: begin
        if (contador_q == '0) begin
          estado_d = RESPOSTA;
        end else begin
          contador_d = contador_q - CW'(1);
        end
      end
      RESPOSTA: begin
        ram_hab_c = 1'b1;
        pronto_d  = 1'b1;
        estado_d  = OCIOSO;
      end
      default: begin
        estado_d = OCIOSO;
      end
    endcase

    ocupado_d = (estado_d != OCIOSO);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado_q   <= OCIOSO;
      contador_q <= '0;
      indice_q   <= '0;
      dado_q     <= '0;
      leitura_q  <= 1'b0;
      pronto_q   <= 1'b0;
      ocupado_q  <= 1'b0;
      erro_q     <= 1'b0;
    end else begin
      estado_q   <= estado_d;
      contador_q <= contador_d;
      indice_q   <= indice_d;
      dado_q     <= dado_d;
      leitura_q  <= leitura_d;
      pronto_q   <= pronto_d;
      ocupado_q  <= ocupado_d;
      erro_q     <= erro_d;
    end
  end

  // The array is touched only in RESPOSTA, so an aborted access never commits.
  memoria_ram #(
    .PROFUNDIDADE (PROFUNDIDADE),
    .AW           (AW)
  ) u_ram (
    .clock        (clock),
    .reset        (reset),
    .habilita     (ram_hab_c),
    .escreve      (!leitura_q),
    .indice       (indice_q),
    .dado_escrita (dado_q),
    .dado_leitura (saidaMemoria)
  );

  assign pronto  = pronto_q;
  assign ocupado = ocupado_q;
  assign erro    = erro_q;

endmodule

// File: tb/tb_controlador_memoria.sv
// Bench for controlador_memoria: LATENCIA=2 instance against a transaction
// model, LATENCIA=0 instance against a fixed vector table.
module tb_controlador_memoria;

  localparam int unsigned LAT_A  = 2;
  localparam int unsigned PROF_A = 256;
  localparam int unsigned PROF_B = 16;
`ifdef MEM_VERIFICA_ERRO_EN
  localparam bit VERIFICA = 1'b1;
`else
  localparam bit VERIFICA = 1'b0;
`endif

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        rst_a, ler_a, esc_a, pronto_a, ocup_a, erro_a;
  logic [31:0] end_a, dado_a, saida_a;
  logic        rst_b, ler_b, esc_b, pronto_b, ocup_b, erro_b;
  logic [31:0] end_b, dado_b, saida_b;

  controlador_memoria #(.LATENCIA(LAT_A), .PROFUNDIDADE(PROF_A)) dut (
    .clock(clock), .reset(rst_a), .ler(ler_a), .escreve(esc_a),
    .endereco(end_a), .dadoEscrita(dado_a), .saidaMemoria(saida_a),
    .pronto(pronto_a), .ocupado(ocup_a), .erro(erro_a)
  );

  controlador_memoria #(.LATENCIA(0), .PROFUNDIDADE(PROF_B)) dut0 (
    .clock(clock), .reset(rst_b), .ler(ler_b), .escreve(esc_b),
    .endereco(end_b), .dadoEscrita(dado_b), .saidaMemoria(saida_b),
    .pronto(pronto_b), .ocupado(ocup_b), .erro(erro_b)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic cmp1(input string nome, input logic got, input logic exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %b, expected %b (t=%0t)", nome, got, exp, $time);
    end
  endtask

  task automatic cmp32(input string nome, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nome, got, exp, $time);
    end
  endtask

  task automatic cmpi(input string nome, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nome, got, exp, $time);
    end
  endtask

  // ---------------- transaction-level model for the LATENCIA=2 instance
  logic [31:0] mem_m [PROF_A];
  bit          mem_k [PROF_A];
  bit          pend, pend_rd;
  int          pend_idx, done_at, cyc;
  logic [31:0] pend_dado, exp_saida;
  bit          saida_k, exp_pronto, exp_erro, exp_ocup;
  int          n_pronto, n_erro, n_ocup;

  function automatic bit addr_ok(input logic [31:0] a);
    return !VERIFICA || ((a[1:0] == 2'b00) && (a[31:2] < 30'(PROF_A)));
  endfunction

  function automatic int word_idx(input logic [31:0] a);
    return int'(a[31:2] % 30'(PROF_A));
  endfunction

  task automatic model_reset();
    pend       = 1'b0;
    exp_pronto = 1'b0;
    exp_erro   = 1'b0;
    exp_ocup   = 1'b0;
    exp_saida  = 32'h0;
    saida_k    = 1'b1;
  endtask

  // An accepted access finishes LATENCIA+1 edges later; until then requests are dropped.
  task automatic model_edge(input logic l, input logic e, input logic [31:0] a, input logic [31:0] d);
    cyc++;
    exp_pronto = 1'b0;
    exp_erro   = 1'b0;
    if (pend) begin
      if (cyc == done_at) begin
        pend       = 1'b0;
        exp_pronto = 1'b1;
        if (pend_rd) begin
          exp_saida = mem_m[pend_idx];
          saida_k   = mem_k[pend_idx];
        end else begin
          mem_m[pend_idx] = pend_dado;
          mem_k[pend_idx] = 1'b1;
        end
      end
    end else if (l && e) begin
      exp_erro = 1'b1;
    end else if (l || e) begin
      if (!addr_ok(a)) begin
        exp_erro = 1'b1;
      end else begin
        pend      = 1'b1;
        pend_rd   = l;
        pend_idx  = word_idx(a);
        pend_dado = d;
        done_at   = cyc + LAT_A + 1;
      end
    end
    exp_ocup = pend;
  endtask

  task automatic check_a(input string tag);
    cmp1({tag, ".ocupado"}, ocup_a, exp_ocup);
    cmp1({tag, ".pronto"}, pronto_a, exp_pronto);
    cmp1({tag, ".erro"}, erro_a, exp_erro);
    if (saida_k) cmp32({tag, ".saida"}, saida_a, exp_saida);
  endtask

  // Called at a falling edge: drive, clock once, check half a cycle later.
  task automatic tick_a(input string tag, input logic l, input logic e,
                        input logic [31:0] a, input logic [31:0] d);
    ler_a  = l;
    esc_a  = e;
    end_a  = a;
    dado_a = d;
    @(posedge clock);
    if (!rst_a) model_edge(l, e, a, d);
    @(negedge clock);
    check_a(tag);
    if (pronto_a) n_pronto++;
    if (erro_a) n_erro++;
    if (ocup_a) n_ocup++;
  endtask

  task automatic acesso_a(input string tag, input logic l, input logic e,
                          input logic [31:0] a, input logic [31:0] d);
    tick_a(tag, l, e, a, d);
    for (int k = 0; k < int'(LAT_A) + 1; k++) tick_a(tag, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic zera_contagem();
    n_pronto = 0;
    n_erro   = 0;
    n_ocup   = 0;
  endtask

  // ---------------- vector table for the LATENCIA=0 instance
  typedef struct {
    logic        l, e;
    logic [31:0] a, d;
    logic        pronto, ocup, erro;
    logic [31:0] saida;
  } vet_t;

  function automatic vet_t vet(input logic l, input logic e, input logic [31:0] a,
                               input logic [31:0] d, input logic p, input logic o,
                               input logic r, input logic [31:0] s);
    vet_t v;
    v.l = l; v.e = e; v.a = a; v.d = d;
    v.pronto = p; v.ocup = o; v.erro = r; v.saida = s;
    return v;
  endfunction

  vet_t tab [16];

  initial begin
    // inputs l e addr data -> after the edge: pronto ocupado erro saida
    tab[0]  = vet(1'b0, 1'b1, 32'h00, 32'hA0,   1'b0, 1'b1, 1'b0, 32'h0);
    tab[1]  = vet(1'b0, 1'b1, 32'h04, 32'hA4,   1'b1, 1'b0, 1'b0, 32'h0);
    tab[2]  = vet(1'b0, 1'b1, 32'h04, 32'hA4,   1'b0, 1'b1, 1'b0, 32'h0);
    tab[3]  = vet(1'b0, 1'b0, 32'h00, 32'h00,   1'b1, 1'b0, 1'b0, 32'h0);
    tab[4]  = vet(1'b1, 1'b0, 32'h00, 32'h00,   1'b0, 1'b1, 1'b0, 32'h0);
    tab[5]  = vet(1'b1, 1'b0, 32'h04, 32'h00,   1'b1, 1'b0, 1'b0, 32'hA0);
    tab[6]  = vet(1'b1, 1'b0, 32'h04, 32'h00,   1'b0, 1'b1, 1'b0, 32'hA0);
    tab[7]  = vet(1'b0, 1'b0, 32'h00, 32'h00,   1'b1, 1'b0, 1'b0, 32'hA4);
    tab[8]  = vet(1'b1, 1'b1, 32'h00, 32'h55,   1'b0, 1'b0, 1'b1, 32'hA4);
    tab[9]  = vet(1'b0, 1'b0, 32'h00, 32'h00,   1'b0, 1'b0, 1'b0, 32'hA4);
    tab[10] = vet(1'b0, 1'b1, 32'h3C, 32'h0F,   1'b0, 1'b1, 1'b0, 32'hA4);
    tab[11] = vet(1'b1, 1'b0, 32'h3C, 32'h00,   1'b1, 1'b0, 1'b0, 32'hA4);
    tab[12] = vet(1'b1, 1'b0, 32'h3C, 32'h00,   1'b0, 1'b1, 1'b0, 32'hA4);
    tab[13] = vet(1'b0, 1'b0, 32'h00, 32'h00,   1'b1, 1'b0, 1'b0, 32'h0F);
    tab[14] = vet(1'b0, 1'b1, 32'h08, 32'hBEEF, 1'b0, 1'b1, 1'b0, 32'h0F);
    tab[15] = vet(1'b0, 1'b0, 32'h00, 32'h00,   1'b1, 1'b0, 1'b0, 32'h0F);

    rst_a = 1'b1; ler_a = 1'b0; esc_a = 1'b0; end_a = 32'h0; dado_a = 32'h0;
    rst_b = 1'b1; ler_b = 1'b0; esc_b = 1'b0; end_b = 32'h0; dado_b = 32'h0;
    cyc = 0;
    zera_contagem();
    model_reset();
    @(negedge clock);
    @(negedge clock);
    check_a("reset_a");
    cmp1("reset_b.pronto", pronto_b, 1'b0);
    cmp1("reset_b.ocupado", ocup_b, 1'b0);
    cmp1("reset_b.erro", erro_b, 1'b0);
    cmp32("reset_b.saida", saida_b, 32'h0);
    rst_a = 1'b0;
    rst_b = 1'b0;

    // LATENCIA=0: back-to-back accesses with a 2-cycle accept period
    for (int i = 0; i < 16; i++) begin
      ler_b = tab[i].l; esc_b = tab[i].e; end_b = tab[i].a; dado_b = tab[i].d;
      @(posedge clock);
      @(negedge clock);
      cmp1($sformatf("tab%0d.pronto", i), pronto_b, tab[i].pronto);
      cmp1($sformatf("tab%0d.ocupado", i), ocup_b, tab[i].ocup);
      cmp1($sformatf("tab%0d.erro", i), erro_b, tab[i].erro);
      cmp32($sformatf("tab%0d.saida", i), saida_b, tab[i].saida);
    end
    ler_b = 1'b0; esc_b = 1'b0;

    // Seed known words used by later sequences.
    acesso_a("init0", 1'b0, 1'b1, 32'h0, 32'h1111_1111);
    acesso_a("init10", 1'b0, 1'b1, 32'h10, 32'h0000_1234);

    // Write 0x8 to 0x4, then read it back.
    zera_contagem();
    acesso_a("w4", 1'b0, 1'b1, 32'h4, 32'h8);
    cmpi("w4.ciclos_ocupado", n_ocup, 3);
    cmpi("w4.prontos", n_pronto, 1);
    zera_contagem();
    tick_a("r4", 1'b1, 1'b0, 32'h4, 32'h0);
    tick_a("r4", 1'b0, 1'b0, 32'h0, 32'h0);
    tick_a("r4", 1'b0, 1'b0, 32'h0, 32'h0);
    cmpi("r4.prontos_cedo", n_pronto, 0);
    tick_a("r4", 1'b0, 1'b0, 32'h0, 32'h0);
    cmp1("r4.pronto_ciclo3", pronto_a, 1'b1);
    cmp32("r4.saida", saida_a, 32'h8);

    // Conflicting request: error pulse, no access.
    zera_contagem();
    tick_a("ambos", 1'b1, 1'b1, 32'h4, 32'hFF);
    cmp1("ambos.ocupado", ocup_a, 1'b0);
    tick_a("ambos", 1'b0, 1'b0, 32'h0, 32'h0);
    cmpi("ambos.erros", n_erro, 1);
    cmp32("ambos.saida", saida_a, 32'h8);

    // Second read during ESPERA is dropped.
    zera_contagem();
    tick_a("dup", 1'b1, 1'b0, 32'h10, 32'h0);
    tick_a("dup", 1'b1, 1'b0, 32'h0, 32'h0);
    tick_a("dup", 1'b1, 1'b0, 32'h0, 32'h0);
    for (int k = 0; k < 4; k++) tick_a("dup", 1'b0, 1'b0, 32'h0, 32'h0);
    cmpi("dup.prontos", n_pronto, 1);
    cmp32("dup.saida", saida_a, 32'h1234);

    // Reset in the middle of a write of 0xDEAD to 0x10.
    zera_contagem();
    tick_a("abort", 1'b0, 1'b1, 32'h10, 32'hDEAD);
    tick_a("abort", 1'b0, 1'b0, 32'h0, 32'h0);
    rst_a = 1'b1;
    #1;
    model_reset();
    check_a("abort.reset_imediato");
    tick_a("abort.em_reset", 1'b0, 1'b0, 32'h0, 32'h0);
    tick_a("abort.em_reset", 1'b0, 1'b0, 32'h0, 32'h0);
    tick_a("abort.em_reset", 1'b0, 1'b0, 32'h0, 32'h0);
    cmpi("abort.prontos", n_pronto, 0);
    rst_a = 1'b0;
    acesso_a("abort.le10", 1'b1, 1'b0, 32'h10, 32'h0);
    cmp32("abort.valor_antigo", saida_a, 32'h1234);

    // Misaligned and out-of-range reads.
    zera_contagem();
    acesso_a("desalinhado", 1'b1, 1'b0, 32'h2, 32'h0);
    cmpi("desalinhado.prontos", n_pronto, VERIFICA ? 0 : 1);
    cmpi("desalinhado.erros", n_erro, VERIFICA ? 1 : 0);
    zera_contagem();
    acesso_a("fora", 1'b1, 1'b0, 32'(4 * PROF_A), 32'h0);
    cmpi("fora.prontos", n_pronto, VERIFICA ? 0 : 1);
    cmpi("fora.erros", n_erro, VERIFICA ? 1 : 0);

    // Random traffic against the model.
    for (int n = 0; n < 600; n++) begin
      int unsigned r, wi;
      logic [31:0] a;
      logic l, e;
      r  = $urandom_range(0, 9);
      wi = $urandom_range(0, 15);
      a  = 32'(wi * 4);
      if ($urandom_range(0, 9) == 0) a = a | 32'($urandom_range(1, 3));
      if ($urandom_range(0, 9) == 0) a = 32'((PROF_A + wi) * 4);
      l = (r <= 2) || (r == 6);
      e = ((r >= 3) && (r <= 5)) || (r == 6);
      tick_a("rand", l, e, a, 32'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/controlador_memoria.md
CONTROLADOR_MEMORIA -- requirements
Module: controlador_memoria

Interface
REQ-001 The block SHALL have parameter LATENCIA, default 2, giving the number of wait cycles inserted before each access completes (legal range 0..15).
REQ-002 The block SHALL have parameter PROFUNDIDADE, default 256, giving the number of 32-bit words stored.
REQ-003 The block SHALL have port clock, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port ler, input, 1 bit: read request from the pipeline.
REQ-006 The block SHALL have port escreve, input, 1 bit: write request from the pipeline.
REQ-007 The block SHALL have port endereco, input, 32 bits: byte address; word index = endereco[31:2].
REQ-008 The block SHALL have port dadoEscrita, input, 32 bits: write data.
REQ-009 The block SHALL have port saidaMemoria, output, 32 bits: registered read data.
REQ-010 The block SHALL have port pronto, output, 1 bit: one-cycle completion pulse.
REQ-011 The block SHALL have port ocupado, output, 1 bit: stall; the pipeline drives PCescreve = ~ocupado.
REQ-012 The block SHALL have port erro, output, 1 bit: one-cycle pulse flagging a rejected request.

Function
REQ-013 The FSM SHALL have the states OCIOSO, ESPERA and RESPOSTA.
REQ-014 In OCIOSO, a rising edge with exactly one of ler/escreve high SHALL latch endereco, dadoEscrita and the operation, and SHALL move to ESPERA (LATENCIA>0, counter loaded with LATENCIA-1) or to RESPOSTA (LATENCIA=0).
REQ-015 ESPERA SHALL decrement the counter each cycle and move to RESPOSTA on the edge where the counter equals 0.
REQ-016 RESPOSTA SHALL last one cycle: a read loads saidaMemoria; a write updates the word; pronto SHALL be high; the next state SHALL be OCIOSO.
REQ-017 pronto SHALL go high exactly LATENCIA+1 cycles after the accepting edge.
REQ-018 ocupado SHALL be high while the state is ESPERA or RESPOSTA, and low in OCIOSO.
REQ-019 Requests arriving while not in OCIOSO SHALL be ignored; they are not queued.
REQ-020 A new request SHALL be accepted in the OCIOSO cycle immediately following RESPOSTA, so back-to-back accesses have a period of LATENCIA+2 cycles.
REQ-021 ler and escreve high together in OCIOSO SHALL pulse erro for one cycle, perform no access and stay in OCIOSO.
REQ-022 saidaMemoria SHALL hold its last value between reads and SHALL be unchanged by writes.
REQ-023 A read of a word written earlier SHALL return the written value.

Reset
REQ-024 reset SHALL force OCIOSO, counter=0, saidaMemoria=0, pronto=0, ocupado=0 and erro=0 immediately, independent of clock.
REQ-025 Reset mid-operation SHALL abort the access: a pending write SHALL NOT be committed, and no pronto SHALL be emitted.
REQ-026 Array contents SHALL NOT be cleared by reset.

Configuration
REQ-027 When macro MEM_VERIFICA_ERRO_EN is defined, a request with endereco[1:0]!=0 or with word index >= PROFUNDIDADE SHALL pulse erro for one cycle, perform no access and stay in OCIOSO.
REQ-028 When MEM_VERIFICA_ERRO_EN is undefined, endereco[1:0] SHALL be ignored, the word index SHALL wrap modulo PROFUNDIDADE, and erro SHALL be asserted only per REQ-021.

Structure
REQ-029 A shared package mem_pkg SHALL hold the FSM state enum, the default LATENCIA/PROFUNDIDADE constants and the 32-bit word typedef.
REQ-030 The storage array SHALL be the sub-module memoria_ram: single-port, synchronous write, registered read, PROFUNDIDADE x 32.

Verification
REQ-031 The bench SHALL cover: LATENCIA=2, escreve with endereco=0x4 and dadoEscrita=0x8 -> ocupado high for 3 cycles, pronto pulses 3 cycles after accept; then ler with endereco=0x4 -> saidaMemoria=0x8 together with pronto.
REQ-032 The bench SHALL cover: ler and escreve both high in OCIOSO -> erro pulse, ocupado stays 0, saidaMemoria unchanged.
REQ-033 The bench SHALL cover: a second ler presented during ESPERA -> ignored, exactly one pronto.
REQ-034 The bench SHALL cover: reset asserted during ESPERA of a write of 0xDEAD to 0x10, then ler of 0x10 -> old value returned, no pronto before reset release.
REQ-035 The bench SHALL cover, with MEM_VERIFICA_ERRO_EN defined: ler at endereco=0x2 -> erro pulse, no access; ler at 4*PROFUNDIDADE -> erro pulse. With it undefined: the same requests complete with pronto.
REQ-036 The bench SHALL cover: LATENCIA=0, back-to-back writes to 0x0 and 0x4 -> pronto pulses one cycle after each accept, accept period 2 cycles.
